// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the ID/EX bundle.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regwe;
    logic        load;
    logic        store;
  } id_ex_t;

  // An all-zero slot reads as "no instruction" to the ALU: no branch, zero result.
  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic imm_type_t imm_type(input logic [6:0] op);
    case (op)
      OP_JALR, OP_LOAD, OP_IMM: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input imm_type_t t, input logic [31:0] instr);
    case (t)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// Integer register file: x1..x31, two async read ports, one sync write port,
// with same-cycle write data bypassed onto the read ports.
module core_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [31:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != 5'd0) rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/core_id_stage.sv
// RV32I decode stage and ID/EX register. Define CORE_ID_FORWARD_EN for EX/MEM
// bypassing; without it, any RAW on an in-flight producer stalls until WB.
module core_id_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_stall,
  input  logic        i_flush,
  output logic        o_jal,
  output logic [31:0] o_jal_target,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_regwe,
  input  logic        i_ex_load,
  input  logic [31:0] i_ex_result,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_regwe,
  input  logic [31:0] i_mem_result,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  output logic [6:0]  o_opcode,
  output logic [6:0]  o_funct7,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_num1u,
  output logic [31:0] o_num2u,
  output logic [31:0] o_pc,
  output logic [31:0] o_immu,
  output logic [4:0]  o_rd,
  output logic        o_regwe,
  output logic        o_load,
  output logic        o_store
);

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, writes_rd;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] num1, num2;
  logic        haz1, haz2, stall_raw;
  id_ex_t      id_ex_d, id_ex_q;

  assign opcode = i_instr[6:0];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign rd     = i_instr[11:7];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_REG: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  core_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2),
    .rdata2 (rf_rdata2),
    .we     (i_wb_we),
    .waddr  (i_wb_rd),
    .wdata  (i_wb_data)
  );

`ifdef CORE_ID_FORWARD_EN
  // Only a load in EX cannot be bypassed: its data does not exist yet.
  assign haz1 = (rs1 != 5'd0) && i_ex_regwe && i_ex_load && (i_ex_rd == rs1);
  assign haz2 = (rs2 != 5'd0) && i_ex_regwe && i_ex_load && (i_ex_rd == rs2);

  always_comb begin
    num1 = rf_rdata1;
    num2 = rf_rdata2;
    if (rs1 != 5'd0) begin
      if (i_ex_regwe && !i_ex_load && i_ex_rd == rs1) num1 = i_ex_result;
      else if (i_mem_regwe && i_mem_rd == rs1)        num1 = i_mem_result;
    end
    if (rs2 != 5'd0) begin
      if (i_ex_regwe && !i_ex_load && i_ex_rd == rs2) num2 = i_ex_result;
      else if (i_mem_regwe && i_mem_rd == rs2)        num2 = i_mem_result;
    end
    if (!use_rs1) num1 = '0;
    if (!use_rs2) num2 = '0;
  end
`else
  assign haz1 = (rs1 != 5'd0) &&
                ((i_ex_regwe && i_ex_rd == rs1) || (i_mem_regwe && i_mem_rd == rs1));
  assign haz2 = (rs2 != 5'd0) &&
                ((i_ex_regwe && i_ex_rd == rs2) || (i_mem_regwe && i_mem_rd == rs2));
  assign num1 = use_rs1 ? rf_rdata1 : '0;
  assign num2 = use_rs2 ? rf_rdata2 : '0;

  logic unused_fwd;
  assign unused_fwd = ^{i_ex_load, i_ex_result, i_mem_result};
`endif

  assign stall_raw    = i_valid && ((use_rs1 && haz1) || (use_rs2 && haz2));
  assign o_stall      = stall_raw && !i_flush && !rst;
  assign o_jal        = i_valid && !i_flush && !rst && !stall_raw && (opcode == OP_JAL);
  assign o_jal_target = i_pc + imm_of(IMM_J, i_instr);

  always_comb begin
    id_ex_d = ID_EX_BUBBLE;
    if (i_valid && !i_flush && !stall_raw) begin
      id_ex_d.valid  = 1'b1;
      id_ex_d.opcode = opcode;
      id_ex_d.funct7 = i_instr[31:25];
      id_ex_d.funct3 = i_instr[14:12];
      id_ex_d.num1   = num1;
      id_ex_d.num2   = num2;
      id_ex_d.pc     = i_pc;
      id_ex_d.imm    = imm_of(imm_type(opcode), i_instr);
      id_ex_d.rd     = rd;
      id_ex_d.regwe  = writes_rd && (rd != 5'd0);
      id_ex_d.load   = (opcode == OP_LOAD);
      id_ex_d.store  = (opcode == OP_STORE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q    <= ID_EX_BUBBLE;
      id_ex_q.pc <= RESET_PC;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign o_valid  = id_ex_q.valid;
  assign o_opcode = id_ex_q.opcode;
  assign o_funct7 = id_ex_q.funct7;
  assign o_funct3 = id_ex_q.funct3;
  assign o_num1u  = id_ex_q.num1;
  assign o_num2u  = id_ex_q.num2;
  assign o_pc     = id_ex_q.pc;
  assign o_immu   = id_ex_q.imm;
  assign o_rd     = id_ex_q.rd;
  assign o_regwe  = id_ex_q.regwe;
  assign o_load   = id_ex_q.load;
  assign o_store  = id_ex_q.store;

endmodule

// File: tb/tb_core_id_stage.sv
// Bench for core_id_stage: directed scenarios plus randomized traffic against a
// per-cycle behavioural model of decode, operand selection and hazards.
module tb_core_id_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0080;

  localparam logic [6:0] M_LUI = 7'h37, M_AUIPC = 7'h17, M_JAL = 7'h6F, M_JALR = 7'h67;
  localparam logic [6:0] M_BR = 7'h63, M_LD = 7'h03, M_ST = 7'h23, M_IMM = 7'h13, M_REG = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, flush;
  logic [31:0] instr, pc;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwe, ex_load, mem_regwe, wb_we;
  logic [31:0] ex_result, mem_result, wb_data;

  logic        o_stall, o_jal, o_valid, o_regwe, o_load, o_store;
  logic [31:0] o_jal_target, o_num1u, o_num2u, o_pc, o_immu;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rd;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        sto;
  } exp_t;

  exp_t        exp_q;
  logic [31:0] rf [32];
  logic        m_stall = 1'b0;

  always #5 clk = ~clk;

  core_id_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (valid),
    .i_instr      (instr),
    .i_pc         (pc),
    .o_stall      (o_stall),
    .i_flush      (flush),
    .o_jal        (o_jal),
    .o_jal_target (o_jal_target),
    .i_ex_rd      (ex_rd),
    .i_ex_regwe   (ex_regwe),
    .i_ex_load    (ex_load),
    .i_ex_result  (ex_result),
    .i_mem_rd     (mem_rd),
    .i_mem_regwe  (mem_regwe),
    .i_mem_result (mem_result),
    .i_wb_we      (wb_we),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .o_valid      (o_valid),
    .o_opcode     (o_opcode),
    .o_funct7     (o_funct7),
    .o_funct3     (o_funct3),
    .o_num1u      (o_num1u),
    .o_num2u      (o_num2u),
    .o_pc         (o_pc),
    .o_immu       (o_immu),
    .o_rd         (o_rd),
    .o_regwe      (o_regwe),
    .o_load       (o_load),
    .o_store      (o_store)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, want, $time);
    end
  endtask

  // Immediates as signed arithmetic on the instruction fields.
  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int s;
    s = ins[31] ? -1 : 0;
    case (ins[6:0])
      M_JALR, M_LD, M_IMM: return s * 2048 + int'(ins[30:20]);
      M_ST:   return s * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      M_BR:   return s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      M_LUI, M_AUIPC: return ins & 32'hFFFF_F000;
      M_JAL:  return s * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                     int'(ins[30:21]) * 2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_haz(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef CORE_ID_FORWARD_EN
    return ex_regwe && ex_load && ex_rd == r;
`else
    return (ex_regwe && ex_rd == r) || (mem_regwe && mem_rd == r);
`endif
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef CORE_ID_FORWARD_EN
    if (ex_regwe && !ex_load && ex_rd == r) return ex_result;
    if (mem_regwe && mem_rd == r) return mem_result;
`endif
    if (wb_we && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  // Called every falling edge: check DUT against the model, then advance the model.
  task automatic model_check();
    exp_t        nx;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, st;
    if (rst) begin
      exp_q    = '0;
      exp_q.pc = RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      m_stall = 1'b0;
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_jal", {31'd0, o_jal}, 32'd0);
    end
    chk("valid", {31'd0, o_valid}, {31'd0, exp_q.v});
    chk("opcode", {25'd0, o_opcode}, {25'd0, exp_q.op});
    chk("funct7", {25'd0, o_funct7}, {25'd0, exp_q.f7});
    chk("funct3", {29'd0, o_funct3}, {29'd0, exp_q.f3});
    chk("num1", o_num1u, exp_q.n1);
    chk("num2", o_num2u, exp_q.n2);
    chk("pc", o_pc, exp_q.pc);
    chk("imm", o_immu, exp_q.imm);
    chk("rd", {27'd0, o_rd}, {27'd0, exp_q.rd});
    chk("regwe", {31'd0, o_regwe}, {31'd0, exp_q.we});
    chk("load", {31'd0, o_load}, {31'd0, exp_q.ld});
    chk("store", {31'd0, o_store}, {31'd0, exp_q.sto});
    if (!rst) begin
      op  = instr[6:0];
      rs1 = instr[19:15];
      rs2 = instr[24:20];
      u1  = op inside {M_JALR, M_BR, M_LD, M_ST, M_IMM, M_REG};
      u2  = op inside {M_BR, M_ST, M_REG};
      st  = valid && !flush && ((u1 && m_haz(rs1)) || (u2 && m_haz(rs2)));
      chk("stall", {31'd0, o_stall}, {31'd0, st});
      chk("jal", {31'd0, o_jal}, {31'd0, valid && !flush && op == M_JAL});
      if (op == M_JAL) chk("jal_target", o_jal_target, pc + m_imm(instr));
      nx = '0;
      if (valid && !flush && !st) begin
        nx.v   = 1'b1;
        nx.op  = op;
        nx.f7  = instr[31:25];
        nx.f3  = instr[14:12];
        nx.n1  = u1 ? m_val(rs1) : 32'd0;
        nx.n2  = u2 ? m_val(rs2) : 32'd0;
        nx.pc  = pc;
        nx.imm = m_imm(instr);
        nx.rd  = instr[11:7];
        nx.we  = (op inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_LD, M_IMM, M_REG}) &&
                 instr[11:7] != 5'd0;
        nx.ld  = op == M_LD;
        nx.sto = op == M_ST;
      end
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
      exp_q   = nx;
      m_stall = st;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; flush = 0; instr = 0; pc = 0;
    ex_rd = 0; ex_regwe = 0; ex_load = 0; ex_result = 0;
    mem_rd = 0; mem_regwe = 0; mem_result = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{M_LUI, M_AUIPC, M_JAL, M_JALR, M_BR, M_LD, M_ST, M_IMM, M_REG, 7'h7F};
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    idle();
    rst = 1;
    settle();
    advance();
    settle();
    chk("lit_rst_pc", o_pc, RESET_PC);
    chk("lit_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("lit_rst_stall", {31'd0, o_stall}, 32'd0);
    advance();
    rst = 0;

    // addi x1,x0,-5
    valid = 1; instr = 32'hFFB00093; pc = 32'h10;
    settle();
    chk("lit_addi_stall", {31'd0, o_stall}, 32'd0);
    advance(); idle();
    chk("lit_addi_op", {25'd0, o_opcode}, 32'h13);
    chk("lit_addi_imm", o_immu, 32'hFFFF_FFFB);
    chk("lit_addi_num1", o_num1u, 32'd0);
    chk("lit_addi_rd", {27'd0, o_rd}, 32'd1);
    chk("lit_addi_regwe", {31'd0, o_regwe}, 32'd1);

    // add x4,x3,x3 with x3 produced by EX
    ex_rd = 3; ex_regwe = 1; ex_result = 32'h1234;
    valid = 1; instr = 32'h00318233; pc = 32'h40;
    settle();
`ifdef CORE_ID_FORWARD_EN
    chk("lit_fwd_stall", {31'd0, o_stall}, 32'd0);
`else
    chk("lit_raw_stall_a", {31'd0, o_stall}, 32'd1);
    advance();
    ex_regwe = 0; mem_rd = 3; mem_regwe = 1; mem_result = 32'h1234;
    settle();
    chk("lit_raw_stall_b", {31'd0, o_stall}, 32'd1);
    advance();
    mem_regwe = 0; wb_we = 1; wb_rd = 3; wb_data = 32'h1234;
    settle();
    chk("lit_raw_stall_c", {31'd0, o_stall}, 32'd0);
`endif
    advance(); idle();
    chk("lit_raw_num1", o_num1u, 32'h1234);
    chk("lit_raw_num2", o_num2u, 32'h1234);

    // lw x5 in EX, sub x6,x5,x1 in ID
    ex_rd = 5; ex_regwe = 1; ex_load = 1;
    valid = 1; instr = 32'h40128333; pc = 32'h44;
    settle();
    chk("lit_lu_stall", {31'd0, o_stall}, 32'd1);
    advance();
    chk("lit_lu_bubble", {31'd0, o_valid}, 32'd0);
    chk("lit_lu_bubble_op", {25'd0, o_opcode}, 32'd0);
    ex_regwe = 0; ex_load = 0; mem_rd = 5; mem_regwe = 1; mem_result = 32'hCAFE;
    settle();
`ifdef CORE_ID_FORWARD_EN
    chk("lit_lu_release", {31'd0, o_stall}, 32'd0);
`else
    chk("lit_lu_mem_stall", {31'd0, o_stall}, 32'd1);
    advance();
    mem_regwe = 0; wb_we = 1; wb_rd = 5; wb_data = 32'hCAFE;
    settle();
    chk("lit_lu_release", {31'd0, o_stall}, 32'd0);
`endif
    advance(); idle();
    chk("lit_lu_num1", o_num1u, 32'hCAFE);

    // WB write-through: x7 <- 0x55 while addi x8,x7,0 is decoded
    wb_we = 1; wb_rd = 7; wb_data = 32'h55;
    valid = 1; instr = 32'h00038413; pc = 32'h50;
    settle(); advance(); idle();
    chk("lit_wt_num1", o_num1u, 32'h55);
    wb_we = 1; wb_rd = 0; wb_data = 32'h99;
    valid = 1; instr = 32'h00000493; pc = 32'h54;
    settle(); advance(); idle();
    chk("lit_x0_num1", o_num1u, 32'd0);

    // jal x1,+16 at 0x100, then the same with a flush
    valid = 1; instr = 32'h010000EF; pc = 32'h100;
    settle();
    chk("lit_jal", {31'd0, o_jal}, 32'd1);
    chk("lit_jal_target", o_jal_target, 32'h110);
    advance(); idle();
    chk("lit_jal_valid", {31'd0, o_valid}, 32'd1);
    chk("lit_jal_pc", o_pc, 32'h100);
    chk("lit_jal_imm", o_immu, 32'h10);
    chk("lit_jal_rd", {27'd0, o_rd}, 32'd1);
    valid = 1; instr = 32'h010000EF; pc = 32'h100; flush = 1;
    settle();
    chk("lit_jal_flushed", {31'd0, o_jal}, 32'd0);
    advance(); idle();
    chk("lit_flush_valid", {31'd0, o_valid}, 32'd0);

    // Reset while a load-use stall is active
    ex_rd = 7; ex_regwe = 1; ex_load = 1;
    valid = 1; instr = 32'h00038513; pc = 32'h48;
    settle();
    chk("lit_pre_rst_stall", {31'd0, o_stall}, 32'd1);
    #1 rst = 1;
    #1;
    chk("lit_mid_rst_stall", {31'd0, o_stall}, 32'd0);
    chk("lit_mid_rst_pc", o_pc, RESET_PC);
    chk("lit_mid_rst_valid", {31'd0, o_valid}, 32'd0);
    advance();
    settle();
    advance();
    rst = 0; idle();
    valid = 1; instr = 32'h00038513; pc = 32'h48;
    settle();
    chk("lit_post_rst_stall", {31'd0, o_stall}, 32'd0);
    advance(); idle();
    chk("lit_post_rst_x7", o_num1u, 32'd0);

    // Randomized traffic; IF honours the stall by holding the instruction
    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        valid = ($urandom_range(0, 9) != 0);
        instr = rand_instr();
        pc    = $urandom & 32'hFFFF_FFFC;
      end
      flush      = ($urandom_range(0, 9) == 0);
      ex_rd      = 5'($urandom_range(0, 7));
      ex_regwe   = 1'($urandom_range(0, 1));
      ex_load    = ($urandom_range(0, 2) == 0);
      ex_result  = $urandom;
      mem_rd     = 5'($urandom_range(0, 7));
      mem_regwe  = 1'($urandom_range(0, 1));
      mem_result = $urandom;
      wb_we      = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      rst        = ($urandom_range(0, 199) == 0);
      settle();
      advance();
    end
    rst = 0; idle();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
